// File: rtl/row_scan_decoder.sv
// Registered N-to-2**N row decoder with a direct mode and an autonomous row-scan mode.
// Optional macro ROW_SCAN_BLANK_EN inserts one all-zero blanking cycle between scanned rows.
module row_scan_decoder #(
  parameter int unsigned N     = 3,
  parameter int unsigned DWELL = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            ena,
  input  logic            mode,
  input  logic [N-1:0]    in,
  output logic [2**N-1:0] out,
  output logic [N-1:0]    row,
  output logic            frame_done
);

  localparam int unsigned Rows     = 2**N;
  localparam logic [7:0]  DwellMax = 8'(DWELL - 1);

  typedef enum logic [1:0] {StIdle, StDirect, StScan} state_e;

  state_e          state_q, state_d;
  logic [Rows-1:0] out_q, out_d;
  logic [N-1:0]    row_q, row_d;
  logic [N-1:0]    row_inc;
  logic            fd_q, fd_d;
  logic [7:0]      cnt_q, cnt_d;
`ifdef ROW_SCAN_BLANK_EN
  logic            blank_q, blank_d;
`endif

  function automatic logic [Rows-1:0] decode(input logic [N-1:0] idx);
    logic [Rows-1:0] oh;
    oh      = '0;
    oh[idx] = 1'b1;
    return oh;
  endfunction

  // Natural N-bit wrap gives the modulo-2**N row increment.
  assign row_inc = row_q + N'(1);

  always_comb begin
    state_d = state_q;
    out_d   = '0;
    row_d   = row_q;
    fd_d    = 1'b0;
    cnt_d   = cnt_q;
`ifdef ROW_SCAN_BLANK_EN
    blank_d = 1'b0;
`endif
    if (!ena) begin
      state_d = StIdle;
      row_d   = '0;
      cnt_d   = '0;
    end else if (!mode) begin
      state_d = StDirect;
      out_d   = decode(in);
      row_d   = in;
      cnt_d   = '0;
    end else if (state_q != StScan) begin
      // Any entry into scan restarts the frame; no frame_done on entry.
      state_d = StScan;
      out_d   = decode('0);
      row_d   = '0;
      cnt_d   = '0;
    end else begin
`ifdef ROW_SCAN_BLANK_EN
      if (blank_q) begin
        // First lit cycle after the blank; row already holds the new index.
        out_d = decode(row_q);
        cnt_d = '0;
        fd_d  = (row_q == '0);
      end else if (cnt_q == DwellMax) begin
        row_d   = row_inc;
        cnt_d   = '0;
        blank_d = 1'b1;
      end else begin
        out_d = decode(row_q);
        cnt_d = cnt_q + 8'd1;
      end
`else
      if (cnt_q == DwellMax) begin
        row_d = row_inc;
        out_d = decode(row_inc);
        cnt_d = '0;
        fd_d  = (row_inc == '0);
      end else begin
        out_d = decode(row_q);
        cnt_d = cnt_q + 8'd1;
      end
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      out_q   <= '0;
      row_q   <= '0;
      fd_q    <= 1'b0;
      cnt_q   <= '0;
`ifdef ROW_SCAN_BLANK_EN
      blank_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      out_q   <= out_d;
      row_q   <= row_d;
      fd_q    <= fd_d;
      cnt_q   <= cnt_d;
`ifdef ROW_SCAN_BLANK_EN
      blank_q <= blank_d;
`endif
    end
  end

  assign out        = out_q;
  assign row        = row_q;
  assign frame_done = fd_q;

endmodule

// File: doc/row_scan_decoder.md
ROW_SCAN_DECODER -- requirements
Module: row_scan_decoder

Interface
REQ-001 SHALL have parameter N, default 3, meaning select width; output width is 2**N; legal range 1..6.
REQ-002 SHALL have parameter DWELL, default 4, meaning clocks each row stays active in scan mode; legal range 1..255.
REQ-003 SHALL have port clk  input  1  meaning the single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst  input  1  meaning synchronous active-high reset.
REQ-005 SHALL have port ena  input  1  meaning global enable; 0 forces all-zero output.
REQ-006 SHALL have port mode  input  1  meaning 0 = direct decode of in, 1 = autonomous row scan.
REQ-007 SHALL have port in  input  N  meaning row select in direct mode; ignored in scan mode.
REQ-008 SHALL have port out  output  2**N  meaning registered one-hot row drive, or all zero.
REQ-009 SHALL have port row  output  N  meaning registered index of the current or next row.
REQ-010 SHALL have port frame_done  output  1  meaning a one-cycle pulse when a scan wraps to row 0.

Function
REQ-011 SHALL implement a state machine with states IDLE, DIRECT and SCAN; the next state is evaluated every clock edge.
REQ-012 SHALL go to IDLE when ena=0, to DIRECT when ena=1 and mode=0, and to SCAN when ena=1 and mode=1.
REQ-013 SHALL, in IDLE, register out=0, row=0, frame_done=0, and clear the dwell counter.
REQ-014 SHALL, in DIRECT, register out = 1<<in and row = in, with 1-cycle latency; in may change every cycle.
REQ-015 SHALL start SCAN at row 0 with a cleared dwell counter whenever SCAN is entered from IDLE or DIRECT, including a mode toggle in mid-scan.
REQ-016 SHALL, in SCAN, hold out = 1<<row for exactly DWELL cycles; row then increments modulo 2**N.
REQ-017 SHALL make the first SCAN output one-hot row 0 on the edge after mode=1/ena=1 is sampled.
REQ-018 SHALL assert frame_done for exactly one cycle, coincident with the first cycle out shows row 0 after row 2**N-1; it SHALL NOT assert on SCAN entry.
REQ-019 SHALL, with DWELL=1, advance the row on every cycle with no skipped or repeated rows.
REQ-020 SHALL, when ena falls mid-scan, make out=0 on the next edge and discard the scan position.
REQ-021 SHALL keep out either one-hot or all-zero in every cycle; it is never multi-hot.

Reset
REQ-022 SHALL, with rst=1 at a clock edge, set state=IDLE, out=0, row=0, frame_done=0 and dwell counter=0, overriding ena and mode.
REQ-023 SHALL, when rst deasserts with ena=1 and mode=1, start scanning at row 0 per REQ-017; a reset in mid-operation leaves no residual state.

Configuration
REQ-024 SHALL use macro ROW_SCAN_BLANK_EN to add anti-ghosting blanking.
- Defined: after each row's DWELL cycles in SCAN, one blanking cycle with out=0 and row already showing the next index. A frame is 2**N*(DWELL+1) cycles. frame_done aligns with the first lit row-0 cycle after the blank.
- Undefined: no blanking cycle. A frame is 2**N*DWELL cycles.
- DIRECT and IDLE behaviour is identical either way.

Verification
REQ-025 SHALL pass the scenarios below, run with N=3 and DWELL=4:
- Direct sweep: rst 2 cycles, then ena=1, mode=0, in=0..7 one per cycle -> out=8'b0000_0001..8'b1000_0000 one cycle later, row=in delayed one cycle.
- Enable low: ena=0, mode=0 and mode=1, all in values -> out=8'h00, row=0, frame_done=0 throughout.
- Full scan, no macro: ena=1, mode=1 for 70 cycles -> each row held 4 cycles in order 0..7; frame_done pulses once at cycle 33 and again at cycle 65 after entry; never multi-hot.
- Blanking, macro defined: same stimulus -> pattern of 4 lit cycles then 1 cycle of out=8'h00; frame period 40 cycles; frame_done once per period.
- Mid-scan disruption: during row 5, drop ena for 1 cycle -> out=0 next edge, then restart at row 0. Repeat with mode toggled to 0 and back -> restart at row 0. Repeat with rst pulsed -> all outputs 0, then row 0.
- DWELL=1 (separate elaboration): scan 20 cycles -> out rotates left by one bit every cycle; frame_done every 8 cycles.
